// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: bundles the ALU-result capture side, the valid/ready
// output side and the status outputs of alu_result_fifo.
//   slave  - the FIFO: takes ALU inputs, out_ready and clr_status; drives head
//            entry, occupancy and status.
//   master - the producer/consumer/control side (the opposite directions).
interface alu_result_fifo_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
);
    // Capture side (from the ALU stage)
    logic                   in_valid;
    logic [31:0]            ALU_Output;
    logic                   Exception;
    logic                   Overflow;
    logic                   Underflow;
    logic [3:0]             Operation;
    // Output side
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_data;
    logic [3:0]             out_op;
    logic [2:0]             out_flags;
    // Occupancy and status
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   clr_status;
    logic                   sticky_exc;
    logic                   sticky_ovf;
    logic                   sticky_unf;
    logic [CNT_W-1:0]       err_count;
    logic [CNT_W-1:0]       drop_count;
    logic                   drop_pulse;

    modport slave (
        input  in_valid, ALU_Output, Exception, Overflow, Underflow, Operation,
        input  out_ready, clr_status,
        output out_valid, out_data, out_op, out_flags, full, count,
        output sticky_exc, sticky_ovf, sticky_unf, err_count, drop_count, drop_pulse
    );

    modport master (
        output in_valid, ALU_Output, Exception, Overflow, Underflow, Operation,
        output out_ready, clr_status,
        input  out_valid, out_data, out_op, out_flags, full, count,
        input  sticky_exc, sticky_ovf, sticky_unf, err_count, drop_count, drop_pulse
    );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: captures floating-point ALU results (value, opcode, flags)
// into a circular FIFO and offers them downstream over valid/ready. The ALU
// cannot be stalled, so results arriving while full are dropped and counted.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_result_fifo_if.slave: ALU inputs, head entry, occupancy,
//          sticky flags, saturating err/drop counters and drop pulse
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    alu_result_fifo_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  op;
        logic [2:0]  flags; // {Exception, Overflow, Underflow}
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             sticky_exc_q, sticky_exc_d;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic             sticky_unf_q, sticky_unf_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             drop_pulse_q;

    logic             full, out_valid, push, pop, drop, err_evt;
    logic [2:0]       in_flags;
    logic [CNT_W-1:0] err_base, drop_base;
    entry_t           head;

    assign full      = (count_q == CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid & ~full;
    assign pop       = out_valid & bus.out_ready;
    // A full FIFO drops even if a pop frees a slot this cycle: no bypass.
    assign drop      = bus.in_valid & full;
    assign in_flags  = {bus.Exception, bus.Overflow, bus.Underflow};
    assign err_evt   = push & (|in_flags);

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{data: bus.ALU_Output, op: bus.Operation, flags: in_flags};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear first, then apply this cycle's event, so a simultaneous event wins.
    always_comb begin
        sticky_exc_d = (sticky_exc_q & ~bus.clr_status) | (push & bus.Exception);
        sticky_ovf_d = (sticky_ovf_q & ~bus.clr_status) | (push & bus.Overflow);
        sticky_unf_d = (sticky_unf_q & ~bus.clr_status) | (push & bus.Underflow);

        err_base  = bus.clr_status ? '0 : err_cnt_q;
        drop_base = bus.clr_status ? '0 : drop_cnt_q;
        err_cnt_d  = err_base;
        drop_cnt_d = drop_base;
        if (err_evt && (err_base != '1)) begin
            err_cnt_d = err_base + CNT_W'(1);
        end
        if (drop && (drop_base != '1)) begin
            drop_cnt_d = drop_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sticky_exc_q <= 1'b0;
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
            err_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sticky_exc_q <= sticky_exc_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
            err_cnt_q    <= err_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_valid ? head.data : '0;
    assign bus.out_op     = out_valid ? head.op : '0;
    assign bus.out_flags  = out_valid ? head.flags : '0;
    assign bus.full       = full;
    assign bus.count      = count_q;
    assign bus.sticky_exc = sticky_exc_q;
    assign bus.sticky_ovf = sticky_ovf_q;
    assign bus.sticky_unf = sticky_unf_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.drop_count = drop_cnt_q;
    assign bus.drop_pulse = drop_pulse_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed self-checking bench for alu_result_fifo.
// Main instance uses DEPTH=4, CNT_W=8; a second instance with CNT_W=2
// exercises counter saturation.
module tb_alu_result_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    alu_result_fifo_if #(.DEPTH(4), .CNT_W(8)) b ();
    alu_result_fifo_if #(.DEPTH(4), .CNT_W(2)) s ();

    alu_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
    alu_result_fifo #(.DEPTH(4), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(s));

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] op,
                         input logic [2:0] fl);
        b.in_valid   = v;
        b.ALU_Output = d;
        b.Operation  = op;
        {b.Exception, b.Overflow, b.Underflow} = fl;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (b.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", b.out_valid); else passed++;
        total++; if (b.count !== 3'd0) $display("FAIL rst_count got %0d want 0", b.count); else passed++;
        total++; if (b.out_data !== 32'h0) $display("FAIL rst_out_data got %h want 0", b.out_data); else passed++;
        total++; if (b.drop_pulse !== 1'b0) $display("FAIL rst_drop_pulse got %b want 0", b.drop_pulse); else passed++;
        rst = 1'b0;
        // Two stored entries, the first flagged, then reset mid-cycle.
        drive(1'b1, 32'h11, 4'h2, 3'b100); step();
        drive(1'b1, 32'h22, 4'h3, 3'b000); step();
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        total++; if (b.count !== 3'd2) $display("FAIL pre_rst_count got %0d want 2", b.count); else passed++;
        total++; if (b.sticky_exc !== 1'b1) $display("FAIL pre_rst_sticky got %b want 1", b.sticky_exc); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (b.out_valid !== 1'b0) $display("FAIL async_rst_valid got %b want 0", b.out_valid); else passed++;
        total++; if (b.count !== 3'd0) $display("FAIL async_rst_count got %0d want 0", b.count); else passed++;
        total++; if (b.sticky_exc !== 1'b0) $display("FAIL async_rst_sticky got %b want 0", b.sticky_exc); else passed++;
        total++; if (b.err_count !== 8'd0) $display("FAIL async_rst_err got %0d want 0", b.err_count); else passed++;
        #1 rst = 1'b0;
        drive(1'b1, 32'h3F800000, 4'h1, 3'b000); step();
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        total++; if (b.out_valid !== 1'b1) $display("FAIL post_rst_valid got %b want 1", b.out_valid); else passed++;
        total++; if (b.out_data !== 32'h3F800000) $display("FAIL post_rst_data got %h want 3f800000", b.out_data); else passed++;
        total++; if (b.out_op !== 4'h1) $display("FAIL post_rst_op got %h want 1", b.out_op); else passed++;
        total++; if (b.count !== 3'd1) $display("FAIL post_rst_count got %0d want 1", b.count); else passed++;
        b.out_ready = 1'b1; step(); b.out_ready = 1'b0;
        total++; if (b.out_valid !== 1'b0) $display("FAIL post_rst_pop got %b want 0", b.out_valid); else passed++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 4'(i), 3'b000); step();
        end
        total++; if (b.full !== 1'b1) $display("FAIL fill_full got %b want 1", b.full); else passed++;
        total++; if (b.count !== 3'd4) $display("FAIL fill_count got %0d want 4", b.count); else passed++;
        drive(1'b1, 32'h5, 4'h5, 3'b000); step();
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        total++; if (b.drop_count !== 8'd1) $display("FAIL drop_count got %0d want 1", b.drop_count); else passed++;
        total++; if (b.drop_pulse !== 1'b1) $display("FAIL drop_pulse_hi got %b want 1", b.drop_pulse); else passed++;
        total++; if (b.count !== 3'd4) $display("FAIL drop_count_occ got %0d want 4", b.count); else passed++;
        step();
        total++; if (b.drop_pulse !== 1'b0) $display("FAIL drop_pulse_lo got %b want 0", b.drop_pulse); else passed++;
        total++; if (b.out_data !== 32'h1) $display("FAIL stall_head got %h want 1", b.out_data); else passed++;
        b.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (b.out_data !== 32'(i)) $display("FAIL drain_data got %h want %h", b.out_data, i); else passed++;
            step();
        end
        b.out_ready = 1'b0;
        total++; if (b.out_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", b.out_valid); else passed++;
    endtask

    task automatic test_wraparound();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 4'h7, 3'b000); step();
            drive(1'b0, 32'h0, 4'h0, 3'b000);
            total++; if (b.out_data !== 32'hA0 + 32'(i)) $display("FAIL wrap_data got %h want %h", b.out_data, 32'hA0 + 32'(i)); else passed++;
            total++; if (b.count !== 3'd1) $display("FAIL wrap_count got %0d want 1", b.count); else passed++;
            b.out_ready = 1'b1; step(); b.out_ready = 1'b0;
        end
        total++; if (b.count !== 3'd0) $display("FAIL wrap_end got %0d want 0", b.count); else passed++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h11, 4'h0, 3'b000); step();
        drive(1'b1, 32'h22, 4'h0, 3'b000); step();
        drive(1'b1, 32'h33, 4'h0, 3'b000); b.out_ready = 1'b1; step();
        drive(1'b0, 32'h0, 4'h0, 3'b000); b.out_ready = 1'b0;
        total++; if (b.count !== 3'd2) $display("FAIL pp2_count got %0d want 2", b.count); else passed++;
        total++; if (b.out_data !== 32'h22) $display("FAIL pp2_head got %h want 22", b.out_data); else passed++;
        drive(1'b1, 32'h44, 4'h0, 3'b000); step();
        drive(1'b1, 32'h55, 4'h0, 3'b000); step();
        drive(1'b1, 32'h66, 4'h0, 3'b000); b.out_ready = 1'b1; step();
        drive(1'b0, 32'h0, 4'h0, 3'b000); b.out_ready = 1'b0;
        total++; if (b.count !== 3'd3) $display("FAIL pp4_count got %0d want 3", b.count); else passed++;
        total++; if (b.drop_count !== 8'd2) $display("FAIL pp4_drop got %0d want 2", b.drop_count); else passed++;
        b.out_ready = 1'b1;
        for (int i = 3; i <= 5; i++) begin
            total++; if (b.out_data !== 32'(i * 17)) $display("FAIL pp4_order got %h want %h", b.out_data, i * 17); else passed++;
            step();
        end
        b.out_ready = 1'b0;
        total++; if (b.out_valid !== 1'b0) $display("FAIL pp4_empty got %b want 0", b.out_valid); else passed++;
    endtask

    task automatic test_flags();
        b.clr_status = 1'b1; step(); b.clr_status = 1'b0;
        total++; if (b.drop_count !== 8'd0) $display("FAIL clr_drop got %0d want 0", b.drop_count); else passed++;
        drive(1'b1, 32'hE1, 4'h8, 3'b100); step();
        drive(1'b1, 32'hE2, 4'h9, 3'b010); step();
        drive(1'b1, 32'hE3, 4'hA, 3'b000); step();
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        total++; if (b.sticky_exc !== 1'b1) $display("FAIL flg_exc got %b want 1", b.sticky_exc); else passed++;
        total++; if (b.sticky_ovf !== 1'b1) $display("FAIL flg_ovf got %b want 1", b.sticky_ovf); else passed++;
        total++; if (b.sticky_unf !== 1'b0) $display("FAIL flg_unf got %b want 0", b.sticky_unf); else passed++;
        total++; if (b.err_count !== 8'd2) $display("FAIL flg_err got %0d want 2", b.err_count); else passed++;
        b.out_ready = 1'b1;
        total++; if (b.out_flags !== 3'b100) $display("FAIL flg_e0 got %b want 100", b.out_flags); else passed++;
        total++; if (b.out_op !== 4'h8) $display("FAIL flg_op0 got %h want 8", b.out_op); else passed++;
        step();
        total++; if (b.out_flags !== 3'b010) $display("FAIL flg_e1 got %b want 010", b.out_flags); else passed++;
        step();
        total++; if (b.out_flags !== 3'b000) $display("FAIL flg_e2 got %b want 000", b.out_flags); else passed++;
        step();
        b.out_ready = 1'b0;
        drive(1'b1, 32'hE4, 4'hB, 3'b001); b.clr_status = 1'b1; step();
        drive(1'b0, 32'h0, 4'h0, 3'b000); b.clr_status = 1'b0;
        total++; if (b.sticky_unf !== 1'b1) $display("FAIL clrev_unf got %b want 1", b.sticky_unf); else passed++;
        total++; if (b.sticky_exc !== 1'b0) $display("FAIL clrev_exc got %b want 0", b.sticky_exc); else passed++;
        total++; if (b.sticky_ovf !== 1'b0) $display("FAIL clrev_ovf got %b want 0", b.sticky_ovf); else passed++;
        total++; if (b.err_count !== 8'd1) $display("FAIL clrev_err got %0d want 1", b.err_count); else passed++;
        total++; if (b.out_flags !== 3'b001) $display("FAIL clrev_flags got %b want 001", b.out_flags); else passed++;
        b.out_ready = 1'b1; step(); b.out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_drop;
        s.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s.ALU_Output = 32'(i); step();
        end
        total++; if (s.full !== 1'b1) $display("FAIL sat_full got %b want 1", s.full); else passed++;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_drop = (k > 3) ? 3 : k;
            total++; if (s.drop_count !== 2'(exp_drop)) $display("FAIL sat_drop got %0d want %0d", s.drop_count, exp_drop); else passed++;
            total++; if (s.drop_pulse !== 1'b1) $display("FAIL sat_pulse got %b want 1", s.drop_pulse); else passed++;
        end
        s.in_valid = 1'b0;
        step();
        total++; if (s.drop_count !== 2'd3) $display("FAIL sat_hold got %0d want 3", s.drop_count); else passed++;
        total++; if (s.drop_pulse !== 1'b0) $display("FAIL sat_pulse_lo got %b want 0", s.drop_pulse); else passed++;
    endtask

    initial begin
        drive(1'b0, 32'h0, 4'h0, 3'b000);
        b.out_ready  = 1'b0;
        b.clr_status = 1'b0;
        s.in_valid   = 1'b0;
        s.ALU_Output = 32'h0;
        s.Operation  = 4'h0;
        s.Exception  = 1'b0;
        s.Overflow   = 1'b0;
        s.Underflow  = 1'b0;
        s.out_ready  = 1'b0;
        s.clr_status = 1'b0;
        test_reset();
        test_fill_drain();
        test_wraparound();
        test_back_to_back();
        test_flags();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
